mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch path and the load/store path. It arbitrates requests, latches the winner's address, write-enable and write data, and drives mem_sel. mem_sel is the select input of the existing 2:1 word mux in front of the memory address port: 0 selects fetch (D1), 1 selects data (D2). It sequences a fixed-latency access with a down-counter and returns a one-cycle acknowledge with registered read data.

Parameters:
WIDTH, 32, address/data word width
LAT, 2, memory access latency in cycles, legal 1..15
CW, 4, wait-counter width, must hold LAT-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  WIDTH  fetch address
d_req  in  1  load/store request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  store data
mem_rdata  in  WIDTH  memory read data, valid in last mem_en cycle
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_sel  out  1  address-mux select, 0 = fetch, 1 = data
mem_addr  out  WIDTH  latched access address
mem_wdata  out  WIDTH  latched store data
if_ack  out  1  one-cycle fetch completion
d_ack  out  1  one-cycle data completion
rdata  out  WIDTH  read data, qualified by if_ack or d_ack

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- All outputs are registered. State is IDLE, GRANT_I or GRANT_D. Internal registers are cnt[CW-1:0] and last_grant (0 = fetch, 1 = data).
- Reset (asynchronous, immediate):
  - state = IDLE, cnt = 0, last_grant = 1.
  - All outputs 0.
  - Reset mid-access abandons the access. No ack is issued after release.
- IDLE, eligibility:
  - A requester is eligible if its req = 1 and its own ack is not asserted this cycle. This stops a re-grant while the requester is dropping req.
  - None eligible: stay in IDLE, mem_en = 0, mem_we = 0.
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant (round-robin). Fetch wins first after reset.
- On a grant edge:
  - mem_addr is latched from the winner's address.
  - For data: mem_we = d_we and mem_wdata = d_wdata. For fetch: mem_we = 0 and mem_wdata is held.
  - mem_sel = winner, mem_en = 1, cnt = LAT-1, last_grant = winner.
  - state moves to GRANT_I or GRANT_D.
- GRANT_x:
  - mem_addr, mem_we, mem_wdata and mem_sel are held stable. Changes on requester inputs are ignored.
  - If cnt != 0, decrement cnt.
  - At the edge where cnt == 0:
    - rdata <= mem_rdata.
    - The matching ack goes to 1 for exactly one cycle.
    - mem_en = 0, mem_we = 0, state = IDLE.
- Timing: with req sampled at edge 0, mem_en is high for LAT cycles and ack is high in the cycle after edge LAT. Minimum request-to-request spacing per requester is LAT+2 cycles.
- Abort: req dropping during a grant does not abort the access. The ack still pulses.
- Idle outputs: mem_addr, mem_sel and mem_wdata hold their last values in IDLE. rdata holds until the next ack.
- Exclusivity: if_ack and d_ack are never both 1. mem_we is never 1 while mem_sel = 0.

Test Plan:
1. LAT=2, fetch only: if_req=1, if_addr=0x40, mem_rdata=0x00500093 -> mem_sel=0, mem_en=1 for 2 cycles, if_ack=1 one cycle later with rdata=0x00500093, d_ack stays 0.
2. After reset, if_req and d_req held high together (if_addr=0x0, d_addr=0x200) -> grants alternate fetch, data, fetch. mem_sel is 0, 1, 0 and mem_addr is 0x0, 0x200, 0x0. Each ack is followed by one IDLE cycle.
3. Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_sel=1, mem_we=1 and mem_wdata=0xDEADBEEF for LAT cycles, then a d_ack pulse and mem_we=0.
4. Load with d_addr changed from 0x100 to 0x104 and d_req dropped during GRANT_D -> mem_addr stays 0x100 and d_ack still pulses.
5. rst_n pulled low in the second mem_en cycle -> mem_en, mem_sel, mem_addr and the acks are 0 immediately. After release with no req, no ack appears within 10 cycles.
6. LAT=1, if_req held continuously -> mem_en is high 1 cycle, if_ack the next cycle, no grant in the ack cycle, next mem_en the cycle after that. The pattern repeats every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: fetch and load/store share one port.
// Round-robin on contention, fixed-latency access timed by a down-counter, one-cycle ack.
module mem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic             mem_sel,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             if_ack,
    output logic             d_ack,
    output logic [WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             last_grant_reg, last_grant_next;
    logic             mem_en_reg, mem_en_next;
    logic             mem_we_reg, mem_we_next;
    logic             mem_sel_reg, mem_sel_next;
    logic [WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic             if_ack_reg, if_ack_next;
    logic             d_ack_reg, d_ack_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;

    // A requester whose ack is showing this cycle is still dropping req; don't re-grant it.
    logic if_elig, d_elig, grant_d;
    assign if_elig = if_req && !if_ack_reg;
    assign d_elig  = d_req && !d_ack_reg;
    assign grant_d = d_elig && (!if_elig || !last_grant_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_sel_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_sel_reg    <= mem_sel_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            if_ack_reg     <= if_ack_next;
            d_ack_reg      <= d_ack_next;
            rdata_reg      <= rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        mem_en_next     = mem_en_reg;
        mem_we_next     = mem_we_reg;
        mem_sel_next    = mem_sel_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        if_ack_next     = 1'b0;
        d_ack_next      = 1'b0;
        rdata_next      = rdata_reg;

        case (state_reg)
            IDLE: begin
                mem_en_next = 1'b0;
                mem_we_next = 1'b0;
                if (if_elig || d_elig) begin
                    mem_en_next     = 1'b1;
                    mem_sel_next    = grant_d;
                    last_grant_next = grant_d;
                    cnt_next        = CW'(LAT - 1);
                    if (grant_d) begin
                        mem_addr_next  = d_addr;
                        mem_we_next    = d_we;
                        mem_wdata_next = d_wdata;
                        state_next     = GRANT_D;
                    end else begin
                        mem_addr_next  = if_addr;
                        state_next     = GRANT_I;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    rdata_next  = mem_rdata;
                    if_ack_next = (state_reg == GRANT_I);
                    d_ack_next  = (state_reg == GRANT_D);
                    mem_en_next = 1'b0;
                    mem_we_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                mem_en_next = 1'b0;
                mem_we_next = 1'b0;
            end
        endcase
    end

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_sel   = mem_sel_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_ack    = if_ack_reg;
    assign d_ack     = d_ack_reg;
    assign rdata     = rdata_reg;

endmodule
